// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-cycle multiply/divide unit
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - request pulse; op/a/b sampled when accepted (IDLE or FIN)
//   op       - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b     - multiplicand/dividend, multiplier/divisor
//   busy     - iterations in progress
//   done     - one-cycle completion pulse
//   hi, lo   - product high/low word, or remainder/quotient
//   div_zero - last divide had b==0; held until the next accepted start
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] m;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             op_signed;
    logic             skip_run;
    logic             last;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    assign accept    = start && ((state == IDLE) || (state == FIN));
    assign op_signed = op[0];
    // Divide by zero never enters RUN; the result is produced on the accepting edge.
    assign skip_run  = op[1] && (b == '0);
    // cnt reaches WIDTH once all iterations are done; that cycle is the sign fix-up cycle.
    assign last      = (cnt == CW'(WIDTH));

    // Magnitudes: -x of 0x80000000 wraps to itself, which is exactly unsigned 2^31.
    assign a_neg = op_signed && a[WIDTH-1];
    assign b_neg = op_signed && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Multiply step: conditional add of the multiplicand, then shift the 2W accumulator right.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);

    // Restoring divide step: shift the next dividend bit into the partial remainder.
    assign div_sh  = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge  = (div_sh >= {1'b0, m});
    // True difference is below m, so the low WIDTH bits are exact even when div_sh[WIDTH] is set.
    assign div_rem = div_sh[WIDTH-1:0] - m;

    assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign q_fix    = neg_q ? -acc_lo : acc_lo;
    assign r_fix    = neg_r ? -acc_hi : acc_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = skip_run ? FIN : RUN;
                end
            end
            RUN: begin
                busy = !last;
                if (last) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                done = 1'b1;
                if (start) begin
                    next_state = skip_run ? FIN : RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            m        <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            if (skip_run) begin
                hi       <= a;
                lo       <= '1;
                div_zero <= 1'b1;
            end else begin
                div_zero <= 1'b0;
                m        <= b_mag;
                acc_hi   <= '0;
                acc_lo   <= a_mag;
            end
        end else if (state == RUN) begin
            if (!last) begin
                cnt <= cnt + CW'(1);
                if (is_div) begin
                    acc_hi <= div_ge ? div_rem : div_sh[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                end else begin
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                end
            end else if (is_div) begin
                hi <= r_fix;
                lo <= q_fix;
            end else begin
                {hi, lo} <= prod_fix;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int n_pass   = 0;
    int n_checks = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic; divides assume y != 0.
    function automatic logic [63:0] model_result(input logic [1:0] o, input logic [31:0] x,
                                                 input logic [31:0] y);
        longint sx;
        longint sy;
        longint p;
        longint q;
        longint r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: res = {32'b0, x} * {32'b0, y};
            2'b01: begin
                p   = sx * sy;
                res = p;
            end
            2'b10: res = {x % y, x / y};
            default: begin
                q   = sx / sy;
                r   = sx % sy;
                res = {r[31:0], q[31:0]};
            end
        endcase
        return res;
    endfunction

    // Behavioural timing model: an accepted op completes 33 edges later; busy for the first 32.
    logic        m_pend  = 1'b0;
    logic        m_done  = 1'b0;
    logic        m_dz    = 1'b0;
    int          m_since = 0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;
    logic [63:0] m_res   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  <= 1'b0;
            m_done  <= 1'b0;
            m_dz    <= 1'b0;
            m_since <= 0;
            m_hi    <= '0;
            m_lo    <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_pend) begin
                m_since <= m_since + 1;
                if (m_since == 32) begin
                    m_pend <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                end
            end else if (start) begin
                if (op[1] && (b == 32'd0)) begin
                    m_done <= 1'b1;
                    m_dz   <= 1'b1;
                    m_hi   <= a;
                    m_lo   <= 32'hFFFF_FFFF;
                end else begin
                    m_pend  <= 1'b1;
                    m_since <= 0;
                    m_dz    <= 1'b0;
                    m_res   <= model_result(op, a, b);
                end
            end
        end
    end

    always @(negedge clk) begin
        check("ctrl busy/done/div_zero", {61'b0, busy, done, div_zero},
              {61'b0, (m_pend && (m_since <= 31)), m_done, m_dz});
        check("result hi/lo", {hi, lo}, {m_hi, m_lo});
    end

    task automatic start_pulse(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called in the cycle after the accepting edge (k=0); lat is the k at which done is seen.
    task automatic wait_done(input int inj, input logic [1:0] io, input logic [31:0] ia,
                             input logic [31:0] ib, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int k = 0; k <= 40; k++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
            start = (k == inj);
            if (k == inj) begin
                op = io;
                a  = ia;
                b  = ib;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int bcnt);
        @(negedge clk);
        start_pulse(o, x, y);
        wait_done(-1, 2'b00, 32'd0, 32'd0, lat, bcnt);
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'd1;
            4:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int          lat;
        int          bc;
        int          ndone;
        int          inj;
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic        dz;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ctrl", {61'b0, busy, done, div_zero}, 64'd0);
        check("reset result", {hi, lo}, 64'd0);
        rst_n = 1'b1;

        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        check("multu latency", 64'(lat), 64'd33);
        check("multu busy cycles", 64'(bc), 64'd32);
        check("multu max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        do_op(2'b01, 32'hFFFF_FFFD, 32'd7, lat, bc);
        check("mult -3*7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bc);
        check("div -7/2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        do_op(2'b10, 32'd100, 32'd0, lat, bc);
        check("divu by zero latency", 64'(lat), 64'd0);
        check("divu by zero busy cycles", 64'(bc), 64'd0);
        check("divu by zero flag", {63'b0, div_zero}, 64'd1);
        check("divu by zero result", {hi, lo}, 64'h0000_0064_FFFF_FFFF);

        do_op(2'b00, 32'd2, 32'd3, lat, bc);
        check("multu 2*3 clears flag", {63'b0, div_zero}, 64'd0);
        check("multu 2*3", {hi, lo}, 64'd6);

        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        check("div minint/-1", {hi, lo}, 64'h0000_0000_8000_0000);

        @(negedge clk);
        start_pulse(2'b10, 32'd10, 32'd3);
        wait_done(5, 2'b10, 32'd50, 32'd5, lat, bc);
        check("divu 10/3 latency", 64'(lat), 64'd33);
        check("divu 10/3 ignores busy start", {hi, lo}, 64'h0000_0001_0000_0003);
        start_pulse(2'b10, 32'd50, 32'd5);
        wait_done(-1, 2'b00, 32'd0, 32'd0, lat, bc);
        check("start in done cycle latency", 64'(lat), 64'd33);
        check("start in done cycle busy", 64'(bc), 64'd32);
        check("divu 50/5", {hi, lo}, 64'h0000_0000_0000_000A);

        @(negedge clk);
        start_pulse(2'b01, 32'd12345, 32'hFFFF_FFF7);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset ctrl", {61'b0, busy, done, div_zero}, 64'd0);
        check("async reset result", {hi, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no done after abort", 64'(ndone), 64'd0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_pulse(2'b00, 32'h0001_0000, 32'h0001_0000);
        wait_done(-1, 2'b00, 32'd0, 32'd0, lat, bc);
        check("first edge after reset latency", 64'(lat), 64'd33);
        check("first edge after reset result", {hi, lo}, 64'h0000_0001_0000_0000);

        for (int i = 0; i < 60; i++) begin
            o   = 2'($urandom_range(0, 3));
            x   = rnd_val();
            y   = rnd_val();
            dz  = o[1] && (y == 32'd0);
            inj = (!dz && ($urandom_range(0, 2) == 0)) ? int'($urandom_range(0, 32)) : -1;
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            start_pulse(o, x, y);
            wait_done(inj, 2'($urandom_range(0, 3)), $urandom, $urandom, lat, bc);
            check("random latency", 64'(lat), dz ? 64'd0 : 64'd33);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
